freelist_mp: RTL and testbench

Parametrised multi-port physical-register free list for the rename stage, the next-generation multi-port free list. It is a circular FIFO of free preg indices. Rename pulls up to ALLOC_NUM indices per cycle through an all-or-nothing handshake, and commit returns up to FREE_NUM indices per cycle with in-order compaction. A branch or exception redirect rolls the head back to a checkpointed pointer in one cycle.

---
 rtl/freelist_mp_if.sv | 33 +++
 rtl/freelist_mp.sv | 100 ++++++++++
 tb/tb_freelist_mp.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/freelist_mp_if.sv
// freelist_mp_if: rename/commit-side bundle for the multi-port free list.
// master = rename/commit logic, slave = the free list itself.
interface freelist_mp_if #(
    parameter int PREG_IDX_WIDTH = 6,
    parameter int PTR_W          = 6,
    parameter int ALLOC_NUM      = 4,
    parameter int FREE_NUM       = 4
);
    logic [ALLOC_NUM-1:0]                alloc_valid;
    logic                                alloc_ready;
    logic [ALLOC_NUM*PREG_IDX_WIDTH-1:0] alloc_preg;
    logic [FREE_NUM-1:0]                 free_valid;
    logic [FREE_NUM*PREG_IDX_WIDTH-1:0]  free_preg;
    logic [PTR_W-1:0]                    head_ptr;
    logic                                recover_valid;
    logic [PTR_W-1:0]                    recover_head;
    logic [PTR_W-1:0]                    free_count;
    logic                                overflow_err;

    modport master (
        output alloc_valid, free_valid, free_preg,
        output recover_valid, recover_head,
        input  alloc_ready, alloc_preg, head_ptr,
        input  free_count, overflow_err
    );

    modport slave (
        input  alloc_valid, free_valid, free_preg,
        input  recover_valid, recover_head,
        output alloc_ready, alloc_preg, head_ptr,
        output free_count, overflow_err
    );
endinterface

// File: rtl/freelist_mp.sv
// freelist_mp: circular FIFO of free preg indices, multi-port alloc/free,
// all-or-nothing allocation grant and one-cycle head rollback.
module freelist_mp #(
    parameter int NUM_PREGS      = 64,
    parameter int NUM_ARCH       = 32,
    parameter int PREG_IDX_WIDTH = 6,
    parameter int PTR_W          = $clog2(NUM_PREGS - NUM_ARCH) + 1,
    parameter int ALLOC_NUM      = 4,
    parameter int FREE_NUM       = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    freelist_mp_if.slave  fl
);
    localparam int DEPTH = NUM_PREGS - NUM_ARCH;
    localparam int IDX_W = PTR_W - 1;
    localparam int W     = PREG_IDX_WIDTH;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] ONE_P   = PTR_W'(1);

    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic             ovf_q, ovf_d;

    logic [PTR_W-1:0]       count;
    logic [PTR_W-1:0]       room;
    logic [PTR_W-1:0]       n_alloc;
    logic [PTR_W-1:0]       n_free;
    logic                   ovf_hit;
    logic                   ready;
    logic [ALLOC_NUM*W-1:0] preg_rd;

    assign count = tail_q - head_q;
    assign room  = DEPTH_P - count;

    // Compact valid alloc ports onto consecutive entries starting at head.
    always_comb begin
        n_alloc = '0;
        preg_rd = '0;
        for (int k = 0; k < ALLOC_NUM; k++) begin
            if (fl.alloc_valid[k]) begin
                preg_rd[k*W +: W] = mem_q[IDX_W'(head_q + n_alloc)];
                n_alloc = n_alloc + ONE_P;
            end
        end
    end

    // Grant only if every requested port can be served; recovery wins.
    always_comb begin
        ready  = (count >= n_alloc) && !fl.recover_valid;
        head_d = head_q;
        if (fl.recover_valid)
            head_d = fl.recover_head;
        else if (ready)
            head_d = head_q + n_alloc;
    end

    // Compact valid frees onto tail; frees beyond the free room are dropped.
    always_comb begin
        mem_d   = mem_q;
        n_free  = '0;
        ovf_hit = 1'b0;
        for (int j = 0; j < FREE_NUM; j++) begin
            if (fl.free_valid[j]) begin
                if (n_free < room) begin
                    mem_d[IDX_W'(tail_q + n_free)] = fl.free_preg[j*W +: W];
                    n_free = n_free + ONE_P;
                end else begin
                    ovf_hit = 1'b1;
                end
            end
        end
        tail_d = tail_q + n_free;
        ovf_d  = ovf_q | ovf_hit;
    end

    // State: pointers, sticky overflow and the index array.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= {1'b1, {IDX_W{1'b0}}};
            ovf_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= W'(NUM_ARCH + i);
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
            mem_q  <= mem_d;
        end
    end

    assign fl.alloc_ready  = ready;
    assign fl.alloc_preg   = preg_rd;
    assign fl.head_ptr     = head_q;
    assign fl.free_count   = count;
    assign fl.overflow_err = ovf_q;
endmodule

// File: tb/tb_freelist_mp.sv
// tb_freelist_mp: directed scenario tests for freelist_mp.
// Each task drives one scenario and checks against hand-computed values.
module tb_freelist_mp;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    freelist_mp_if fl ();

    freelist_mp dut (
        .clk_i (clk),
        .rst_i (rst),
        .fl    (fl)
    );

    task automatic idle();
        fl.alloc_valid   = '0;
        fl.free_valid    = '0;
        fl.free_preg     = '0;
        fl.recover_valid = 1'b0;
        fl.recover_head  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        tick();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        tick();
        rst = 1'b1;
        #1;
        tests++;
        if (fl.alloc_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got %0d exp 1", fl.alloc_ready);
        end
        tests++;
        if (fl.free_count !== 6'd32) begin
            fails++;
            $display("FAIL reset_count got %0d exp 32", fl.free_count);
        end
        tests++;
        if (fl.head_ptr !== 6'd0) begin
            fails++;
            $display("FAIL reset_head got %0d exp 0", fl.head_ptr);
        end
        tests++;
        if (fl.overflow_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_ovf got %0d exp 0", fl.overflow_err);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_alloc4();
        do_reset();
        fl.alloc_valid = 4'b1111;
        #1;
        tests++;
        if (fl.alloc_ready !== 1'b1) begin
            fails++;
            $display("FAIL alloc4_ready got %0d exp 1", fl.alloc_ready);
        end
        tests++;
        if (fl.alloc_preg !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
            fails++;
            $display("FAIL alloc4_preg got %h exp %h", fl.alloc_preg,
                     {6'd35, 6'd34, 6'd33, 6'd32});
        end
        tick();
        idle();
        tests++;
        if (fl.head_ptr !== 6'd4) begin
            fails++;
            $display("FAIL alloc4_head got %0d exp 4", fl.head_ptr);
        end
        tests++;
        if (fl.free_count !== 6'd28) begin
            fails++;
            $display("FAIL alloc4_count got %0d exp 28", fl.free_count);
        end
    endtask

    task automatic test_compaction();
        do_reset();
        fl.alloc_valid = 4'b1010;
        #1;
        tests++;
        if (fl.alloc_preg !== {6'd33, 6'd0, 6'd32, 6'd0}) begin
            fails++;
            $display("FAIL compact_preg got %h exp %h", fl.alloc_preg,
                     {6'd33, 6'd0, 6'd32, 6'd0});
        end
        tick();
        idle();
        tests++;
        if (fl.head_ptr !== 6'd2) begin
            fails++;
            $display("FAIL compact_head got %0d exp 2", fl.head_ptr);
        end
    endtask

    task automatic test_drain_free();
        do_reset();
        fl.alloc_valid = 4'b1111;
        repeat (8) tick();
        idle();
        tests++;
        if (fl.free_count !== 6'd0) begin
            fails++;
            $display("FAIL drain_count got %0d exp 0", fl.free_count);
        end
        fl.alloc_valid = 4'b0001;
        fl.free_valid  = 4'b0001;
        fl.free_preg   = 24'd5;
        #1;
        tests++;
        if (fl.alloc_ready !== 1'b0) begin
            fails++;
            $display("FAIL empty_ready got %0d exp 0", fl.alloc_ready);
        end
        tick();
        fl.free_valid = '0;
        fl.free_preg  = '0;
        #1;
        tests++;
        if (fl.alloc_ready !== 1'b1) begin
            fails++;
            $display("FAIL refill_ready got %0d exp 1", fl.alloc_ready);
        end
        tests++;
        if (fl.alloc_preg[5:0] !== 6'd5) begin
            fails++;
            $display("FAIL refill_preg got %0d exp 5", fl.alloc_preg[5:0]);
        end
        tests++;
        if (fl.free_count !== 6'd1) begin
            fails++;
            $display("FAIL refill_count got %0d exp 1", fl.free_count);
        end
        idle();
    endtask

    task automatic test_partial();
        do_reset();
        fl.alloc_valid = 4'b1111;
        repeat (7) tick();
        fl.alloc_valid = 4'b0001;
        tick();
        idle();
        tests++;
        if (fl.free_count !== 6'd3) begin
            fails++;
            $display("FAIL partial_count got %0d exp 3", fl.free_count);
        end
        fl.alloc_valid = 4'b1111;
        #1;
        tests++;
        if (fl.alloc_ready !== 1'b0) begin
            fails++;
            $display("FAIL partial_ready got %0d exp 0", fl.alloc_ready);
        end
        tick();
        tests++;
        if (fl.head_ptr !== 6'd29) begin
            fails++;
            $display("FAIL partial_head got %0d exp 29", fl.head_ptr);
        end
        fl.alloc_valid = 4'b0111;
        #1;
        tests++;
        if (fl.alloc_ready !== 1'b1) begin
            fails++;
            $display("FAIL fit_ready got %0d exp 1", fl.alloc_ready);
        end
        tests++;
        if (fl.alloc_preg !== {6'd0, 6'd63, 6'd62, 6'd61}) begin
            fails++;
            $display("FAIL fit_preg got %h exp %h", fl.alloc_preg,
                     {6'd0, 6'd63, 6'd62, 6'd61});
        end
        tick();
        idle();
        tests++;
        if (fl.free_count !== 6'd0) begin
            fails++;
            $display("FAIL fit_count got %0d exp 0", fl.free_count);
        end
    endtask

    task automatic test_recover();
        logic [5:0] ckpt;
        do_reset();
        ckpt = 6'd0;
        tests++;
        if (fl.head_ptr !== ckpt) begin
            fails++;
            $display("FAIL ckpt_head got %0d exp 0", fl.head_ptr);
        end
        fl.alloc_valid = 4'b1111;
        repeat (2) tick();
        idle();
        tests++;
        if (fl.head_ptr !== 6'd8) begin
            fails++;
            $display("FAIL rec_pre_head got %0d exp 8", fl.head_ptr);
        end
        fl.recover_valid = 1'b1;
        fl.recover_head  = ckpt;
        fl.alloc_valid   = 4'b1111;
        #1;
        tests++;
        if (fl.alloc_ready !== 1'b0) begin
            fails++;
            $display("FAIL rec_ready got %0d exp 0", fl.alloc_ready);
        end
        tick();
        idle();
        tests++;
        if (fl.head_ptr !== 6'd0) begin
            fails++;
            $display("FAIL rec_head got %0d exp 0", fl.head_ptr);
        end
        fl.alloc_valid = 4'b1111;
        #1;
        tests++;
        if (fl.alloc_preg !== {6'd35, 6'd34, 6'd33, 6'd32}) begin
            fails++;
            $display("FAIL rec_preg got %h exp %h", fl.alloc_preg,
                     {6'd35, 6'd34, 6'd33, 6'd32});
        end
        idle();
    endtask

    task automatic test_overflow();
        do_reset();
        fl.free_valid = 4'b0011;
        fl.free_preg  = {6'd0, 6'd0, 6'd2, 6'd1};
        tick();
        idle();
        tests++;
        if (fl.overflow_err !== 1'b1) begin
            fails++;
            $display("FAIL ovf_flag got %0d exp 1", fl.overflow_err);
        end
        tests++;
        if (fl.free_count !== 6'd32) begin
            fails++;
            $display("FAIL ovf_count got %0d exp 32", fl.free_count);
        end
        fl.alloc_valid = 4'b0001;
        #1;
        tests++;
        if (fl.alloc_preg[5:0] !== 6'd32) begin
            fails++;
            $display("FAIL ovf_drop got %0d exp 32", fl.alloc_preg[5:0]);
        end
        idle();
        tick();
        tests++;
        if (fl.overflow_err !== 1'b1) begin
            fails++;
            $display("FAIL ovf_sticky got %0d exp 1", fl.overflow_err);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (fl.overflow_err !== 1'b0) begin
            fails++;
            $display("FAIL ovf_reset got %0d exp 0", fl.overflow_err);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_wrap();
        int          q[$];
        logic [23:0] prev;
        logic [23:0] exp;
        do_reset();
        for (int i = 0; i < 32; i++) q.push_back(32 + i);
        prev = '0;
        for (int c = 0; c < 20; c++) begin
            if (c == 8) begin
                tests++;
                if (fl.head_ptr[5] !== 1'b1) begin
                    fails++;
                    $display("FAIL wrap_bit got %0d exp 1", fl.head_ptr[5]);
                end
            end
            fl.alloc_valid = 4'b1111;
            fl.free_valid  = (c > 0) ? 4'b1111 : 4'b0000;
            fl.free_preg   = prev;
            #1;
            for (int k = 0; k < 4; k++) exp[k*6 +: 6] = 6'(q.pop_front());
            if (c > 0)
                for (int k = 0; k < 4; k++) q.push_back(int'(prev[k*6 +: 6]));
            tests++;
            if (fl.alloc_preg !== exp) begin
                fails++;
                $display("FAIL wrap_alloc c=%0d got %h exp %h", c,
                         fl.alloc_preg, exp);
            end
            prev = exp;
            tick();
        end
        idle();
        tests++;
        if (fl.head_ptr !== 6'd16) begin
            fails++;
            $display("FAIL wrap_head got %0d exp 16", fl.head_ptr);
        end
        tests++;
        if (fl.free_count !== 6'd28) begin
            fails++;
            $display("FAIL wrap_count got %0d exp 28", fl.free_count);
        end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        test_reset();
        test_alloc4();
        test_compaction();
        test_drain_free();
        test_partial();
        test_recover();
        test_overflow();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
